// File: rtl/exc_commit_ctrl.sv
// ---------------------------------------------------------------------------
// exc_commit_ctrl
//
// Commit-side exception/interrupt initiator between the memory stage and the
// CP0 register block. One retiring instruction is accepted per handshake;
// its raw exception flags and the interrupt indication sampled at acceptance
// are resolved into one prioritised one-hot exc_type. The block drives the
// CP0 exception / eret / mtc0 inputs for exactly one COMMIT cycle, flushes
// younger stages and requests a redirect to EXC_VECTOR (exception) or EPC
// (eret).
//
// Handshake: an instruction moves when in_valid & in_ready are both high on a
// rising clk edge; in_ready is high only in IDLE. The redirect moves when
// redirect_valid & redirect_ready are both high on a rising clk edge;
// redirect_valid stays high and redirect_pc stays stable until then.
//
// Optional build macro: EXC_COUNT_EN adds exc_count[31:0], the number of
// COMMIT cycles that carried a nonzero exc_type (wrapping).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   instruction handshake from the memory stage
//   in_pc, in_is_slot     instruction PC and delay-slot flag
//   in_exc                raw flags {adel, ades, sys, bp, ri, ov}
//   in_badvaddr           faulting address (used when adel wins)
//   in_eret, in_mtc0      instruction kind
//   in_cp0_addr, in_wdata mtc0 {rd, sel} address and data
//   int_happen            CP0 pending-interrupt indication
//   epc                   CP0 EPC value (eret target)
//   exc_type              {int, adel, ades, sys, bp, ri, ov}, one-hot or zero
//   exc_pc, exc_is_slot   PC / slot flag to CP0
//   exc_bad_vaddr         bad address to CP0
//   eret_o                eret pulse to CP0
//   cp0_wen, cp0_addr,
//   cp0_wdata             mtc0 write port to CP0
//   flush                 kill all younger pipeline stages
//   redirect_valid/_pc/
//   redirect_ready        redirect handshake to fetch
//   exc_count             (EXC_COUNT_EN only) committed-exception counter
//   o_dbg_state           current FSM state for observation
// ---------------------------------------------------------------------------
module exc_commit_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic        in_is_slot,
   input  logic [5:0]  in_exc,
   input  logic [31:0] in_badvaddr,
   input  logic        in_eret,
   input  logic        in_mtc0,
   input  logic [7:0]  in_cp0_addr,
   input  logic [31:0] in_wdata,
   input  logic        int_happen,
   input  logic [31:0] epc,
   output logic [6:0]  exc_type,
   output logic [31:0] exc_pc,
   output logic        exc_is_slot,
   output logic [31:0] exc_bad_vaddr,
   output logic        eret_o,
   output logic        cp0_wen,
   output logic [7:0]  cp0_addr,
   output logic [31:0] cp0_wdata,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
`ifdef EXC_COUNT_EN
   output logic [31:0] exc_count,
`endif
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_COMMIT   = 2'd1,
      S_FLUSH    = 2'd2,
      S_REDIRECT = 2'd3
   } state_t;

   // COMMIT already provides the first flush cycle, so FLUSH holds the rest.
   localparam logic [3:0] L_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam bit         L_SKIP_FLUSH = (FLUSH_CYCLES == 1);

   state_t      r_state;
   logic [3:0]  r_flush_cnt;
   logic        r_is_exc;
   logic        r_do_redirect;
   logic [6:0]  r_exc_type;
   logic [31:0] r_exc_pc;
   logic        r_exc_is_slot;
   logic [31:0] r_exc_bad_vaddr;
   logic        r_eret_o;
   logic        r_cp0_wen;
   logic [7:0]  r_cp0_addr;
   logic [31:0] r_cp0_wdata;
   logic        r_flush;
   logic        r_redirect_valid;
   logic [31:0] r_redirect_pc;

   logic [6:0]  w_exc_type;
   logic        w_has_exc;

   // Priority resolve: int, adel, ri, ov, sys, bp, ades.
   // in_exc bit map: [5]=adel [4]=ades [3]=sys [2]=bp [1]=ri [0]=ov.
   always_comb begin
      w_exc_type = '0;
      if (int_happen)     w_exc_type[6] = 1'b1;
      else if (in_exc[5]) w_exc_type[5] = 1'b1;
      else if (in_exc[1]) w_exc_type[1] = 1'b1;
      else if (in_exc[0]) w_exc_type[0] = 1'b1;
      else if (in_exc[3]) w_exc_type[3] = 1'b1;
      else if (in_exc[2]) w_exc_type[2] = 1'b1;
      else if (in_exc[4]) w_exc_type[4] = 1'b1;
      w_has_exc = |w_exc_type;
   end

   // CP0-facing outputs are loaded on acceptance so they are live exactly in
   // COMMIT, and cleared on leaving COMMIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_flush_cnt      <= '0;
         r_is_exc         <= 1'b0;
         r_do_redirect    <= 1'b0;
         r_exc_type       <= '0;
         r_exc_pc         <= '0;
         r_exc_is_slot    <= 1'b0;
         r_exc_bad_vaddr  <= '0;
         r_eret_o         <= 1'b0;
         r_cp0_wen        <= 1'b0;
         r_cp0_addr       <= '0;
         r_cp0_wdata      <= '0;
         r_flush          <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_state         <= S_COMMIT;
                  r_is_exc        <= w_has_exc;
                  r_do_redirect   <= w_has_exc | in_eret;
                  r_exc_type      <= w_exc_type;
                  r_exc_pc        <= in_pc;
                  r_exc_is_slot   <= in_is_slot;
                  r_exc_bad_vaddr <= w_exc_type[5] ? in_badvaddr : 32'd0;
                  // An exception suppresses both eret and the mtc0 write.
                  r_eret_o        <= ~w_has_exc & in_eret;
                  r_cp0_wen       <= ~w_has_exc & in_mtc0;
                  r_cp0_addr      <= (~w_has_exc & in_mtc0) ? in_cp0_addr : 8'd0;
                  r_cp0_wdata     <= (~w_has_exc & in_mtc0) ? in_wdata : 32'd0;
                  r_flush         <= w_has_exc | in_eret;
               end
            end
            S_COMMIT: begin
               r_exc_type      <= '0;
               r_exc_pc        <= '0;
               r_exc_is_slot   <= 1'b0;
               r_exc_bad_vaddr <= '0;
               r_eret_o        <= 1'b0;
               r_cp0_wen       <= 1'b0;
               r_cp0_addr      <= '0;
               r_cp0_wdata     <= '0;
               if (r_do_redirect) begin
                  // EPC is taken as CP0 presents it during COMMIT.
                  r_redirect_pc <= r_is_exc ? EXC_VECTOR : epc;
                  if (L_SKIP_FLUSH) begin
                     r_state          <= S_REDIRECT;
                     r_flush          <= 1'b0;
                     r_redirect_valid <= 1'b1;
                  end else begin
                     r_state     <= S_FLUSH;
                     r_flush_cnt <= L_FLUSH_LOAD;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_FLUSH: begin
               r_flush_cnt <= r_flush_cnt - 4'd1;
               if (r_flush_cnt == 4'd1) begin
                  r_state          <= S_REDIRECT;
                  r_flush          <= 1'b0;
                  r_redirect_valid <= 1'b1;
               end
            end
            S_REDIRECT: begin
               if (redirect_ready) begin
                  r_state          <= S_IDLE;
                  r_redirect_valid <= 1'b0;
                  r_redirect_pc    <= '0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef EXC_COUNT_EN
   logic [31:0] r_exc_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_exc_count <= '0;
      end else if ((r_state == S_COMMIT) && (|r_exc_type)) begin
         r_exc_count <= r_exc_count + 32'd1;
      end
   end

   assign exc_count = r_exc_count;
`endif

   assign in_ready       = (r_state == S_IDLE);
   assign exc_type       = r_exc_type;
   assign exc_pc         = r_exc_pc;
   assign exc_is_slot    = r_exc_is_slot;
   assign exc_bad_vaddr  = r_exc_bad_vaddr;
   assign eret_o         = r_eret_o;
   assign cp0_wen        = r_cp0_wen;
   assign cp0_addr       = r_cp0_addr;
   assign cp0_wdata      = r_cp0_wdata;
   assign flush          = r_flush;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exc_commit_ctrl
//
// Directed bench for exc_commit_ctrl. A transaction-level model tracks each
// accepted instruction by its cycle offset from COMMIT and checks every DUT
// output on every negative clock edge; directed sequences also pin the
// expected results with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_exc_commit_ctrl;

   localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
   localparam int          FC         = 2;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic        in_is_slot;
   logic [5:0]  in_exc;
   logic [31:0] in_badvaddr;
   logic        in_eret;
   logic        in_mtc0;
   logic [7:0]  in_cp0_addr;
   logic [31:0] in_wdata;
   logic        int_happen;
   logic [31:0] epc;
   logic [6:0]  exc_type;
   logic [31:0] exc_pc;
   logic        exc_is_slot;
   logic [31:0] exc_bad_vaddr;
   logic        eret_o;
   logic        cp0_wen;
   logic [7:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic [1:0]  o_dbg_state;
`ifdef EXC_COUNT_EN
   logic [31:0] exc_count;
`endif

   exc_commit_ctrl #(
      .EXC_VECTOR   (EXC_VECTOR),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pc          (in_pc),
      .in_is_slot     (in_is_slot),
      .in_exc         (in_exc),
      .in_badvaddr    (in_badvaddr),
      .in_eret        (in_eret),
      .in_mtc0        (in_mtc0),
      .in_cp0_addr    (in_cp0_addr),
      .in_wdata       (in_wdata),
      .int_happen     (int_happen),
      .epc            (epc),
      .exc_type       (exc_type),
      .exc_pc         (exc_pc),
      .exc_is_slot    (exc_is_slot),
      .exc_bad_vaddr  (exc_bad_vaddr),
      .eret_o         (eret_o),
      .cp0_wen        (cp0_wen),
      .cp0_addr       (cp0_addr),
      .cp0_wdata      (cp0_wdata),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready),
`ifdef EXC_COUNT_EN
      .exc_count      (exc_count),
`endif
      .o_dbg_state    (o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic chk_en = 1'b0;
   always @(posedge clk) if (rst) chk_en <= 1'b1;

   // ---------------- check helper ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // Exception priority as a list of exc_type bit positions, highest first.
   int          prio [7] = '{6, 5, 1, 0, 3, 2, 4};
   bit          m_busy = 1'b0;
   int          m_d;
   logic [6:0]  m_type;
   logic [31:0] m_pc, m_bad, m_wdata, m_target;
   logic        m_slot, m_eret, m_wen, m_redir;
   logic [7:0]  m_addr;
   logic [31:0] m_cnt = 32'd0;
   logic [6:0]  raw;

   logic        e_ready, e_slot, e_eret, e_wen, e_flush, e_rv;
   logic [6:0]  e_type;
   logic [31:0] e_pc, e_bad, e_wdata;
   logic [7:0]  e_addr;

   always @(negedge clk) begin
      if (chk_en) begin
         if (m_busy) m_d++;
         e_ready = !m_busy;
         e_type = '0; e_pc = '0; e_slot = 1'b0; e_bad = '0; e_eret = 1'b0;
         e_wen = 1'b0; e_addr = '0; e_wdata = '0; e_flush = 1'b0; e_rv = 1'b0;
         if (m_busy && m_d == 0) begin
            e_type = m_type; e_pc = m_pc; e_slot = m_slot; e_bad = m_bad;
            e_eret = m_eret; e_wen = m_wen; e_addr = m_addr; e_wdata = m_wdata;
            e_flush = m_redir;
            if (m_type == 7'd0) m_target = epc;
            else                m_target = EXC_VECTOR;
         end
         if (m_busy && m_redir && m_d > 0 && m_d < FC) e_flush = 1'b1;
         if (m_busy && m_redir && m_d >= FC)          e_rv = 1'b1;

         check("m_in_ready", in_ready, e_ready);
         check("m_exc_type", exc_type, e_type);
         check("m_exc_pc", exc_pc, e_pc);
         check("m_exc_is_slot", exc_is_slot, e_slot);
         check("m_exc_bad_vaddr", exc_bad_vaddr, e_bad);
         check("m_eret_o", eret_o, e_eret);
         check("m_cp0_wen", cp0_wen, e_wen);
         check("m_cp0_addr", cp0_addr, e_addr);
         check("m_cp0_wdata", cp0_wdata, e_wdata);
         check("m_flush", flush, e_flush);
         check("m_redirect_valid", redirect_valid, e_rv);
         if (e_rv) check("m_redirect_pc", redirect_pc, m_target);
`ifdef EXC_COUNT_EN
         check("m_exc_count", exc_count, m_cnt);
`endif

         // advance model to the next cycle
         if (m_busy && m_d == 0 && m_type != 7'd0) m_cnt = m_cnt + 32'd1;
         if (m_busy) begin
            if (!m_redir && m_d == 0) m_busy = 1'b0;
            else if (m_redir && m_d >= FC && redirect_ready) m_busy = 1'b0;
         end
         if (e_ready && in_valid) begin
            raw = {int_happen, in_exc};
            m_type = '0;
            for (int i = 0; i < 7; i++) begin
               if (m_type == 7'd0 && raw[prio[i]]) m_type[prio[i]] = 1'b1;
            end
            m_pc    = in_pc;
            m_slot  = in_is_slot;
            m_bad   = m_type[5] ? in_badvaddr : 32'd0;
            m_eret  = (m_type == 7'd0) && in_eret;
            m_wen   = (m_type == 7'd0) && in_mtc0;
            m_addr  = m_wen ? in_cp0_addr : 8'd0;
            m_wdata = m_wen ? in_wdata : 32'd0;
            m_redir = (m_type != 7'd0) || in_eret;
            m_busy  = 1'b1;
            m_d     = -1;
         end
         if (rst) begin
            m_busy = 1'b0;
            m_cnt  = 32'd0;
         end
      end
   end

   // ---------------- driver ----------------
   typedef struct {
      logic [6:0]  etype;
      logic [31:0] pc;
      logic        slot;
      logic [31:0] bad;
      int          n_eret;
      int          n_wen;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          n_flush;
      int          n_rv;
      logic [31:0] rpc;
      int          n_busy;
   } obs_t;

   task automatic send(input logic [31:0] pc, input logic slot, input logic [5:0] exc,
                       input logic [31:0] bad, input logic eret, input logic mtc0,
                       input logic [7:0] addr, input logic [31:0] wdata, input logic intr,
                       input logic [31:0] epc_v, input int rr_delay, output obs_t o);
      int nred;
      bit done;
      o = '{default: 0};
      @(posedge clk); #1;
      in_valid = 1'b1; in_pc = pc; in_is_slot = slot; in_exc = exc; in_badvaddr = bad;
      in_eret = eret; in_mtc0 = mtc0; in_cp0_addr = addr; in_wdata = wdata;
      int_happen = intr; epc = epc_v; redirect_ready = (rr_delay == 0);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         else begin @(posedge clk); #1; end
      end
      if (!done) begin
         check("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      // Scramble inputs after acceptance: the latched copy must be used.
      in_valid = 1'b0; in_pc = ~pc; in_is_slot = ~slot; in_exc = ~exc; in_badvaddr = ~bad;
      in_eret = 1'b0; in_mtc0 = 1'b0; in_cp0_addr = ~addr; in_wdata = ~wdata;
      int_happen = ~intr;
      nred = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         else begin
            if (o.n_busy == 0) begin
               o.etype = exc_type; o.pc = exc_pc; o.slot = exc_is_slot; o.bad = exc_bad_vaddr;
            end
            o.n_busy++;
            if (flush) o.n_flush++;
            if (eret_o) o.n_eret++;
            if (cp0_wen) begin o.n_wen++; o.addr = cp0_addr; o.wdata = cp0_wdata; end
            if (redirect_valid) begin o.n_rv++; o.rpc = redirect_pc; nred++; end
            @(posedge clk); #1;
            if (o.n_busy == 1) epc = 32'hDEAD0000;
            redirect_ready = (nred >= rr_delay);
         end
      end
      if (!done) check("busy_timeout", 32'd0, 32'd1);
      int_happen = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   obs_t o;
   int   n_rv_after;
`ifdef EXC_COUNT_EN
   logic [31:0] cnt_base;
`endif

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_is_slot = 1'b0; in_exc = '0;
      in_badvaddr = '0; in_eret = 1'b0; in_mtc0 = 1'b0; in_cp0_addr = '0; in_wdata = '0;
      int_happen = 1'b0; epc = '0; redirect_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 32'd1);
      check("rst_exc_type", exc_type, 32'd0);
      check("rst_flush", flush, 32'd0);
      check("rst_redirect_valid", redirect_valid, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_cp0_wen", cp0_wen, 32'd0);

      // Idle with a pending interrupt and no instruction: nothing happens.
      @(posedge clk); #1 int_happen = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_int_exc_type", exc_type, 32'd0);
      check("idle_int_flush", flush, 32'd0);
      @(posedge clk); #1 int_happen = 1'b0;

      // ov only
      send(32'h80001000, 1'b0, 6'b000001, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 0, o);
      check("ov_exc_type", o.etype, 32'h01);
      check("ov_exc_pc", o.pc, 32'h80001000);
      check("ov_flush_cycles", o.n_flush, 32'd2);
      check("ov_redirect_cycles", o.n_rv, 32'd1);
      check("ov_redirect_pc", o.rpc, 32'hBFC00380);
      check("ov_busy_cycles", o.n_busy, 32'd3);

      // Reset asserted during FLUSH
      @(posedge clk); #1;
      in_valid = 1'b1; in_pc = 32'h80002000; in_exc = 6'b000001; redirect_ready = 1'b1;
      @(negedge clk);
      check("rstf_accept_ready", in_ready, 32'd1);
      @(posedge clk); #1 in_valid = 1'b0; in_exc = '0;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("rstf_flush_before", flush, 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rstf_flush", flush, 32'd0);
      check("rstf_redirect_valid", redirect_valid, 32'd0);
      check("rstf_in_ready", in_ready, 32'd1);
      n_rv_after = 0;
      repeat (6) begin
         @(negedge clk);
         if (redirect_valid) n_rv_after++;
      end
      check("rstf_no_redirect", n_rv_after, 32'd0);

`ifdef EXC_COUNT_EN
      cnt_base = exc_count;
`endif
      // adel+ri+ov with interrupt sampled at acceptance
      send(32'h80003000, 1'b0, 6'b100011, 32'h12345677, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 32'h0, 0, o);
      check("int_exc_type", o.etype, 32'h40);
      check("int_bad_vaddr", o.bad, 32'h0);

      // same without interrupt, in a delay slot
      send(32'h80003004, 1'b1, 6'b100011, 32'h12345677, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 0, o);
      check("adel_exc_type", o.etype, 32'h20);
      check("adel_bad_vaddr", o.bad, 32'h12345677);
      check("adel_slot", o.slot, 32'd1);

      // mtc0 with sys: write suppressed
      send(32'h80004000, 1'b0, 6'b001000, 32'h0, 1'b0, 1'b1, 8'h60, 32'h0000FF01, 1'b0, 32'h0, 0, o);
      check("mtc0sys_wen", o.n_wen, 32'd0);
      check("mtc0sys_exc_type", o.etype, 32'h08);
      check("mtc0sys_flush", o.n_flush, 32'd2);

      // eret with slow fetch
      send(32'h80005000, 1'b0, 6'b000000, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0, 1'b0, 32'hBFC00400, 5, o);
      check("eret_pulses", o.n_eret, 32'd1);
      check("eret_exc_type", o.etype, 32'd0);
      check("eret_redirect_cycles", o.n_rv, 32'd6);
      check("eret_redirect_pc", o.rpc, 32'hBFC00400);
      check("eret_flush_cycles", o.n_flush, 32'd2);

      // plain mtc0
      send(32'h80006000, 1'b0, 6'b000000, 32'h0, 1'b0, 1'b1, 8'h60, 32'h0000FF01, 1'b0, 32'h0, 0, o);
      check("mtc0_wen", o.n_wen, 32'd1);
      check("mtc0_addr", o.addr, 32'h60);
      check("mtc0_wdata", o.wdata, 32'h0000FF01);
      check("mtc0_flush", o.n_flush, 32'd0);
      check("mtc0_redirect", o.n_rv, 32'd0);
      check("mtc0_busy_cycles", o.n_busy, 32'd1);
`ifdef EXC_COUNT_EN
      check("exc_count_delta", exc_count - cnt_base, 32'd3);
`endif

      // remaining priority pairs
      send(32'h80007000, 1'b0, 6'b010100, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 0, o);
      check("ades_bp_exc_type", o.etype, 32'h04);
      send(32'h80007004, 1'b0, 6'b010000, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 0, o);
      check("ades_exc_type", o.etype, 32'h10);
      send(32'h80007008, 1'b0, 6'b001010, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 0, o);
      check("ri_sys_exc_type", o.etype, 32'h02);
      send(32'h8000700C, 1'b0, 6'b001001, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 0, o);
      check("ov_sys_exc_type", o.etype, 32'h01);
      check("exc_eret_suppressed", o.n_eret, 32'd0);
      check("exc_eret_redirect_pc", o.rpc, 32'hBFC00380);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
